// File: rtl/axi4_wr_burst_split.sv
// Splits one large write request into AXI4 bursts bounded by MAX_BURST and 4KB pages.
// Each burst leaves as one {id, addr, len} stream word; out_tlast flags the request's final burst.
module axi4_wr_burst_split #(
   parameter int ASIZE     = 32,
   parameter int IDSIZE    = 4,
   parameter int LSIZE     = 8,
   parameter int DSIZE     = 32,
   parameter int MAX_BURST = 256,
   parameter int TSIZE     = 32
) (
   input  logic                          clock,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [IDSIZE-1:0]             req_id,
   input  logic [ASIZE-1:0]              req_addr,
   input  logic [TSIZE-1:0]              req_beats,
   output logic                          out_tvalid,
   input  logic                          out_tready,
   output logic [IDSIZE+ASIZE+LSIZE-1:0] out_tdata,
   output logic                          out_tlast,
   output logic                          busy
);

   localparam int BPB  = DSIZE / 8;
   localparam int BOFF = $clog2(BPB);
   // Wide enough for remain, MAX_BURST and the 4KB page beat count without overflow
   localparam int CW   = ((TSIZE > 13) ? TSIZE : 13) + 1;
   localparam logic [ASIZE-1:0] AMASK = ~ASIZE'(BPB - 1);

   typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;

   state_t            state, state_next;
   logic [IDSIZE-1:0] id;
   logic [ASIZE-1:0]  addr;
   logic [TSIZE-1:0]  remain;
   logic [CW-1:0]     nb;
   logic [CW-1:0]     nb_c, to_4k, remain_w;
   logic              accept, done;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         req_ready <= 1'b0;
      end else begin
         state     <= state_next;
         busy      <= (state_next != IDLE);
         req_ready <= (state_next == IDLE);
      end
   end

   always_comb begin
      accept     = req_valid && req_ready;
      remain_w   = CW'(remain);
      to_4k      = CW'((13'd4096 - {1'b0, addr[11:0]}) >> BOFF);
      nb_c       = remain_w;
      if (CW'(MAX_BURST) < nb_c) nb_c = CW'(MAX_BURST);
      if (to_4k < nb_c)          nb_c = to_4k;
      done       = (remain_w == nb);
      state_next = state;
      case (state)
         IDLE: if (accept && req_beats != '0) state_next = CALC;
         CALC: state_next = SEND;
         SEND: if (out_tready) state_next = done ? IDLE : CALC;
         default: state_next = IDLE;
      endcase
   end

   assign out_tvalid = (state == SEND);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         id        <= '0;
         addr      <= '0;
         remain    <= '0;
         nb        <= '0;
         out_tdata <= '0;
         out_tlast <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               id     <= req_id;
               addr   <= req_addr & AMASK;
               remain <= req_beats;
            end
            CALC: begin
               nb        <= nb_c;
               out_tdata <= {id, addr, LSIZE'(nb_c - CW'(1))};
               out_tlast <= (remain_w == nb_c);
            end
            SEND: if (out_tready) begin
               addr   <= addr + (ASIZE'(nb) << BOFF);
               remain <= remain - TSIZE'(nb);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_wr_burst_split.sv
// Scoreboard bench for axi4_wr_burst_split: a reference model fills expected-burst queues
// at request issue; a monitor pops and compares on every output handshake.
module tb_axi4_wr_burst_split;

   localparam int ASIZE = 32, IDSIZE = 4, LSIZE = 8, DSIZE = 32, MAX_BURST = 256, TSIZE = 32;
   localparam int BPB = DSIZE / 8;
   localparam int DW  = IDSIZE + ASIZE + LSIZE;

   logic              clock = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic [IDSIZE-1:0] req_id;
   logic [ASIZE-1:0]  req_addr;
   logic [TSIZE-1:0]  req_beats;
   logic              out_tvalid;
   logic              out_tready = 1'b0;
   logic [DW-1:0]     out_tdata;
   logic              out_tlast;
   logic              busy;

   axi4_wr_burst_split #(
      .ASIZE(ASIZE), .IDSIZE(IDSIZE), .LSIZE(LSIZE),
      .DSIZE(DSIZE), .MAX_BURST(MAX_BURST), .TSIZE(TSIZE)
   ) dut (
      .clock(clock), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
      .req_addr(req_addr), .req_beats(req_beats),
      .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
      .out_tlast(out_tlast), .busy(busy)
   );

   always #5 clock = ~clock;

   int            total = 0;
   int            bad   = 0;
   logic [DW-1:0] exp_data[$];
   logic          exp_last[$];

   logic             stall_en = 1'b0;
   logic [ASIZE-1:0] stall_addr = '0;
   int               stall_len = 0;
   int               stall_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, req, $time);
      end
   endtask

   // Reference: walk the request in page/max-limited chunks using plain integer arithmetic
   function automatic void model(input logic [IDSIZE-1:0] id, input logic [ASIZE-1:0] a,
                                 input longint beats);
      longint ad  = longint'(a) & ~longint'(BPB - 1);
      longint rem = beats;
      longint to4k, nb;
      while (rem > 0) begin
         to4k = (4096 - (ad % 4096)) / BPB;
         nb   = rem;
         if (nb > MAX_BURST) nb = MAX_BURST;
         if (nb > to4k)      nb = to4k;
         exp_data.push_back({id, ad[ASIZE-1:0], LSIZE'(nb - 1)});
         exp_last.push_back(rem == nb);
         ad  = (ad + nb * BPB) % (longint'(1) << ASIZE);
         rem = rem - nb;
      end
   endfunction

   // Downstream ready: random, with an optional stall window on one burst address
   always @(posedge clock) begin
      #1;
      if (stall_en && out_tvalid && out_tdata[LSIZE +: ASIZE] == stall_addr && stall_cnt < stall_len) begin
         out_tready = 1'b0;
         stall_cnt++;
      end else begin
         out_tready = ($urandom_range(0, 3) != 0);
      end
   end

   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   logic [DW-1:0] wd;
   logic          wl;

   always @(negedge clock) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         chk("ready_while_busy", {63'd0, req_ready & busy}, 64'd0);
         if (prev_stall) begin
            chk("stall_valid", {63'd0, out_tvalid}, 64'd1);
            chk("stall_data", 64'(out_tdata), 64'(prev_data));
            chk("stall_last", {63'd0, out_tlast}, {63'd0, prev_last});
         end
         if (out_tvalid && out_tready) begin
            total++;
            if (exp_data.size() == 0) begin
               bad++;
               $display("FAIL unexpected_burst got=%h want=none t=%0t", out_tdata, $time);
            end else begin
               wd = exp_data.pop_front();
               wl = exp_last.pop_front();
               if (out_tdata !== wd || out_tlast !== wl) begin
                  bad++;
                  $display("FAIL burst got=%h/%b want=%h/%b t=%0t", out_tdata, out_tlast, wd, wl, $time);
               end
            end
         end
         prev_stall = out_tvalid && !out_tready;
         prev_data  = out_tdata;
         prev_last  = out_tlast;
      end
   end

   task automatic send_req(input logic [IDSIZE-1:0] id, input logic [ASIZE-1:0] a,
                           input logic [TSIZE-1:0] b);
      int n = 0;
      @(posedge clock); #1;
      while (!req_ready && n < 3000) begin
         @(posedge clock); #1;
         n++;
      end
      chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1;
      req_id    = id;
      req_addr  = a;
      req_beats = b;
      model(id, a, longint'(b));
      @(posedge clock); #1;
      req_valid = 1'b0;
      req_id    = IDSIZE'($urandom);
      req_addr  = $urandom;
      req_beats = $urandom;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || exp_data.size() != 0) && n < 8000) begin
         @(negedge clock);
         n++;
      end
      chk("drain_busy", {63'd0, busy}, 64'd0);
      chk("drain_queue", 64'(exp_data.size()), 64'd0);
   endtask

   task automatic wait_stall();
      int n = 0;
      while (stall_cnt == 0 && n < 3000) begin
         @(negedge clock);
         n++;
      end
      chk("stall_seen", {63'd0, stall_cnt > 0}, 64'd1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd0);
      chk({tag, "_tvalid"}, {63'd0, out_tvalid}, 64'd0);
      chk({tag, "_tdata"}, 64'(out_tdata), 64'd0);
      chk({tag, "_tlast"}, {63'd0, out_tlast}, 64'd0);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
   endtask

   logic [ASIZE-1:0] ra;
   logic [TSIZE-1:0] rb;

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_id = '0; req_addr = '0; req_beats = '0;
      repeat (3) @(posedge clock);
      #1 chk_zero("reset");
      @(negedge clock) rst_n = 1'b1;

      // Single burst, then a MAX_BURST split, then a 4KB crossing
      send_req(4'h3, 32'h0000_0000, 32'd16);
      wait_idle();
      send_req(4'h5, 32'h0000_0000, 32'd600);
      wait_idle();
      send_req(4'ha, 32'h0000_0FF0, 32'd10);
      wait_idle();

      // Zero-beat request is swallowed, then a single-beat request
      send_req(4'h1, 32'h0000_1234, 32'd0);
      chk("zero_busy", {63'd0, busy}, 64'd0);
      chk("zero_ready", {63'd0, req_ready}, 64'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("zero_tvalid", {63'd0, out_tvalid}, 64'd0);
      end
      send_req(4'h2, 32'h0000_0100, 32'd1);
      wait_idle();

      // Five-cycle backpressure on the second burst
      stall_cnt = 0; stall_len = 5; stall_addr = 32'h0000_0400; stall_en = 1'b1;
      send_req(4'h6, 32'h0000_0000, 32'd600);
      wait_stall();
      for (int i = 0; i < 5; i++) begin
         chk("bp_tvalid", {63'd0, out_tvalid}, 64'd1);
         chk("bp_tdata", 64'(out_tdata), 64'({4'h6, 32'h0000_0400, 8'hff}));
         chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
         @(negedge clock);
      end
      wait_idle();
      stall_en = 1'b0;

      // Reset while the second burst is held in SEND
      stall_cnt = 0; stall_len = 100000; stall_addr = 32'h0000_0400; stall_en = 1'b1;
      send_req(4'h7, 32'h0000_0000, 32'd600);
      wait_stall();
      repeat (2) @(negedge clock);
      rst_n = 1'b0;
      #1 chk_zero("midrst");
      exp_data.delete();
      exp_last.delete();
      stall_en = 1'b0;
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      send_req(4'h3, 32'h0000_0000, 32'd16);
      wait_idle();

      // Random requests, issued back to back
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0: ra = $urandom;
            1: ra = {$urandom_range(0, 1048575), 12'h000} | 32'(12'hF00 + $urandom_range(0, 255));
            2: ra = 32'hFFFF_F000 + 32'($urandom_range(0, 4095));
            default: ra = 32'($urandom_range(0, 8191));
         endcase
         case ($urandom_range(0, 3))
            0: rb = 32'($urandom_range(0, 3));
            1: rb = 32'($urandom_range(250, 260));
            default: rb = 32'($urandom_range(0, 900));
         endcase
         send_req(IDSIZE'($urandom), ra, rb);
      end
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
